// File: rtl/cache_pkg.sv
// Shared types and constants for the two-way data cache.
// Address split: tag = addr[17:8], index = addr[7:2].
package cache_pkg;

  localparam int SETS    = 64;
  localparam int TAG_W   = 10;
  localparam int INDEX_W = 6;

  localparam int IDX_LO = 2;
  localparam int IDX_HI = IDX_LO + INDEX_W - 1;
  localparam int TAG_LO = IDX_HI + 1;
  localparam int TAG_HI = TAG_LO + TAG_W - 1;

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WR_THRU
  } state_t;

endpackage

// File: rtl/data_cache_ctrl_if.sv
// MEM-stage side bus of the data cache.
// Pipeline is master; the cache is slave.
interface data_cache_ctrl_if;

  logic        mem_r_en;
  logic        mem_w_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output mem_r_en, mem_w_en, addr, wdata,
    input  rdata, ready
  );

  modport slave (
    input  mem_r_en, mem_w_en, addr, wdata,
    output rdata, ready
  );

endinterface

// File: rtl/cache_way.sv
// One way of the cache: valid/tag/data arrays.
// Async lookup, sync write, async clear of valid.
module cache_way
  import cache_pkg::*;
#(
  parameter int SETS  = cache_pkg::SETS,
  parameter int TAG_W = cache_pkg::TAG_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] idx,
  input  logic [TAG_W-1:0]   tag,
  input  logic               we,
  input  logic [31:0]        wdata,
  output logic               hit,
  output logic [31:0]        data
);

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags  [SETS];
  logic [31:0]      words [SETS];

  assign hit  = valid[idx] && (tags[idx] == tag);
  assign data = words[idx];

  // valid bits: cleared on reset, set on any fill/update
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      valid <= '0;
    else if (we)
      valid[idx] <= 1'b1;
  end

  // tag and data arrays: plain synchronous write
  always_ff @(posedge clk) begin
    if (we) begin
      tags[idx]  <= tag;
      words[idx] <= wdata;
    end
  end

endmodule

// File: rtl/data_cache_ctrl.sv
// Two-way write-through, no-write-allocate data cache.
// Read hits are combinational; misses/writes stall on SRAM.
module data_cache_ctrl
  import cache_pkg::*;
#(
  parameter int SETS  = cache_pkg::SETS,
  parameter int TAG_W = cache_pkg::TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  data_cache_ctrl_if.slave  mem,
  output logic              sram_r_en,
  output logic              sram_w_en,
  output logic [31:0]       sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  input  logic              sram_ready
);

  state_t state, state_nx;

  logic               seen_busy;
  logic [SETS-1:0]    lru;
  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               hit0, hit1;
  logic [31:0]        data0, data1;
  logic               hit, hit_way;
  logic [31:0]        hit_data;
  logic               done;
  logic               we0, we1;
  logic [31:0]        fill;
  logic               lru_we, lru_val;

  assign idx        = mem.addr[IDX_HI:IDX_LO];
  assign tag        = mem.addr[TAG_HI:TAG_LO];
  assign sram_addr  = mem.addr;
  assign sram_wdata = mem.wdata;

  assign hit      = hit0 | hit1;
  assign hit_way  = ~hit0;
  assign hit_data = hit0 ? data0 : data1;

  // first-cycle Ready is the controller's idle-high; ignore it
  assign done = seen_busy & sram_ready;

  cache_way #(.SETS(SETS), .TAG_W(TAG_W)) u_way0 (
    .clk   (clk),
    .rst   (rst),
    .idx   (idx),
    .tag   (tag),
    .we    (we0),
    .wdata (fill),
    .hit   (hit0),
    .data  (data0)
  );

  cache_way #(.SETS(SETS), .TAG_W(TAG_W)) u_way1 (
    .clk   (clk),
    .rst   (rst),
    .idx   (idx),
    .tag   (tag),
    .we    (we1),
    .wdata (fill),
    .hit   (hit1),
    .data  (data1)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // cleared while idle, so it starts low in each request
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      seen_busy <= 1'b0;
    else if (state == IDLE)
      seen_busy <= 1'b0;
    else if (!sram_ready)
      seen_busy <= 1'b1;
  end

  // LRU bit per set names the way to evict next
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lru <= '0;
    else if (lru_we)
      lru[idx] <= lru_val;
  end

  // next state, handshake outputs and array write controls
  always_comb begin
    state_nx  = state;
    mem.ready = 1'b1;
    mem.rdata = '0;
    sram_r_en = 1'b0;
    sram_w_en = 1'b0;
    we0       = 1'b0;
    we1       = 1'b0;
    fill      = mem.wdata;
    lru_we    = 1'b0;
    lru_val   = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem.mem_w_en) begin
          state_nx  = WR_THRU;
          mem.ready = 1'b0;
        end else if (mem.mem_r_en) begin
          if (hit) begin
            mem.rdata = hit_data;
            lru_we    = 1'b1;
            lru_val   = ~hit_way;
          end else begin
            state_nx  = RD_MISS;
            mem.ready = 1'b0;
          end
        end
      end
      RD_MISS: begin
        sram_r_en = 1'b1;
        mem.ready = done;
        fill      = sram_rdata;
        if (done) begin
          mem.rdata = sram_rdata;
          we0       = ~lru[idx];
          we1       = lru[idx];
          lru_we    = 1'b1;
          lru_val   = ~lru[idx];
          state_nx  = IDLE;
        end
      end
      WR_THRU: begin
        sram_w_en = 1'b1;
        mem.ready = done;
        if (done) begin
          if (hit) begin
            we0     = ~hit_way;
            we1     = hit_way;
            lru_we  = 1'b1;
            lru_val = ~hit_way;
          end
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Bench for data_cache_ctrl: SRAM controller model plus
// an MRU-list reference of each set's cached tags.
module tb_data_cache_ctrl;

  localparam int NSETS = 64;

  logic        clk;
  logic        rst;
  logic        sram_r_en;
  logic        sram_w_en;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        sram_ready;

  data_cache_ctrl_if mem ();

  data_cache_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .mem        (mem),
    .sram_r_en  (sram_r_en),
    .sram_w_en  (sram_w_en),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .sram_ready (sram_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] smem    [65536];
  logic [31:0] ref_mem [65536];
  logic [9:0]  lines   [NSETS][$];

  int          scnt;
  logic        lat_w;
  logic [15:0] lat_a;
  logic [31:0] lat_d;

  assign sram_ready = (scnt == 0) || (scnt == 5);
  assign sram_rdata = (scnt == 5) ? smem[lat_a] : 32'hBAD0_0000;

  // SRAM controller: idle, 4 busy cycles, one READY cycle
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt <= 0;
    end else if (scnt == 0) begin
      if (sram_r_en || sram_w_en) begin
        scnt  <= 1;
        lat_w <= sram_w_en;
        lat_a <= sram_addr[17:2];
        lat_d <= sram_wdata;
      end
    end else if (scnt == 5) begin
      if (lat_w) smem[lat_a] <= lat_d;
      scnt <= 0;
    end else begin
      scnt <= scnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // true-LRU over two ways; reads allocate, writes only touch
  function automatic bit model_access(input bit is_wr,
                                      input logic [31:0] a);
    int ix;
    int pos;
    logic [9:0] t;
    ix  = int'(a[7:2]);
    t   = a[17:8];
    pos = -1;
    for (int i = 0; i < lines[ix].size(); i++)
      if (lines[ix][i] == t) pos = i;
    if (pos >= 0) begin
      lines[ix].delete(pos);
      lines[ix].push_front(t);
      return 1'b1;
    end
    if (!is_wr) begin
      lines[ix].push_front(t);
      if (lines[ix].size() > 2) void'(lines[ix].pop_back());
    end
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NSETS; i++) lines[i].delete();
  endtask

  // called #1 after a rising edge; returns the same way
  task automatic access(input bit w, input bit r,
                        input logic [31:0] a, input logic [31:0] d);
    bit          hit;
    int          stalls;
    int          en_r;
    int          en_w;
    logic [31:0] got;
    logic [31:0] exp_d;
    hit   = model_access(w, a);
    exp_d = ref_mem[a[17:2]];
    if (w) ref_mem[a[17:2]] = d;
    mem.mem_w_en = w;
    mem.mem_r_en = r;
    mem.addr     = a;
    mem.wdata    = d;
    stalls = 0;
    en_r   = 0;
    en_w   = 0;
    @(negedge clk);
    while (mem.ready !== 1'b1 && stalls < 20) begin
      en_r += int'(sram_r_en);
      en_w += int'(sram_w_en);
      stalls++;
      @(negedge clk);
    end
    en_r += int'(sram_r_en);
    en_w += int'(sram_w_en);
    got = mem.rdata;
    chk("stall_cycles", 32'(stalls), (w || !hit) ? 32'd6 : 32'd0);
    chk("sram_r_en_cycles", 32'(en_r),
        (!w && !hit) ? 32'd6 : 32'd0);
    chk("sram_w_en_cycles", 32'(en_w), w ? 32'd6 : 32'd0);
    if (!w) chk("rdata", got, exp_d);
    @(posedge clk);
    #1;
    mem.mem_w_en = 1'b0;
    mem.mem_r_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rnd;
    logic [31:0] a;
    logic [9:0]  tg;
    logic [5:0]  ix;
    int          op;

    for (int i = 0; i < 65536; i++) begin
      rnd        = $urandom();
      smem[i]    = rnd;
      ref_mem[i] = rnd;
    end
    smem[32'h400 >> 2]    = 32'h1234_5678;
    ref_mem[32'h400 >> 2] = 32'h1234_5678;
    model_clear();

    rst          = 1'b1;
    mem.mem_r_en = 1'b0;
    mem.mem_w_en = 1'b0;
    mem.addr     = '0;
    mem.wdata    = '0;

    @(negedge clk);
    chk("reset_ready", {31'd0, mem.ready}, 32'd1);
    chk("reset_rdata", mem.rdata, 32'd0);
    chk("reset_sram_r_en", {31'd0, sram_r_en}, 32'd0);
    chk("reset_sram_w_en", {31'd0, sram_w_en}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // cold miss then hit
    access(1'b0, 1'b1, 32'h0000_0400, 32'h0);
    access(1'b0, 1'b1, 32'h0000_0400, 32'h0);

    // same-set fills and eviction
    access(1'b0, 1'b1, 32'h0000_0500, 32'h0);
    access(1'b0, 1'b1, 32'h0000_0600, 32'h0);
    access(1'b0, 1'b1, 32'h0000_0500, 32'h0);
    access(1'b0, 1'b1, 32'h0000_0400, 32'h0);

    // write-through hit, then read back from cache
    access(1'b1, 1'b0, 32'h0000_0400, 32'hDEAD_BEEF);
    access(1'b0, 1'b1, 32'h0000_0400, 32'h0);

    // write to uncached line: no allocate
    access(1'b1, 1'b0, 32'h0000_0800, 32'hCAFE_0001);
    access(1'b0, 1'b1, 32'h0000_0800, 32'h0);

    // write wins over read
    access(1'b1, 1'b1, 32'h0000_0404, 32'h0BAD_F00D);
    access(1'b0, 1'b1, 32'h0000_0404, 32'h0);

    // idle between requests
    @(negedge clk);
    chk("idle_ready", {31'd0, mem.ready}, 32'd1);
    chk("idle_rdata", mem.rdata, 32'd0);
    @(posedge clk);
    #1;

    // reset in the middle of a read miss
    mem.mem_r_en = 1'b1;
    mem.addr     = 32'h0000_0900;
    repeat (3) @(posedge clk);
    #1;
    rst          = 1'b1;
    mem.mem_r_en = 1'b0;
    @(negedge clk);
    chk("rst_mid_sram_r_en", {31'd0, sram_r_en}, 32'd0);
    chk("rst_mid_ready", {31'd0, mem.ready}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    access(1'b0, 1'b1, 32'h0000_0900, 32'h0);
    access(1'b0, 1'b1, 32'h0000_0400, 32'h0);

    // random traffic over a few sets and tags
    for (int n = 0; n < 150; n++) begin
      rnd = $urandom();
      tg  = 10'($urandom_range(0, 4));
      ix  = 6'($urandom_range(0, 3));
      a   = {rnd[31:18], tg, ix, 2'b00};
      op  = $urandom_range(0, 9);
      if (op < 3)
        access(1'b1, 1'b0, a, $urandom());
      else if (op == 3)
        access(1'b1, 1'b1, a, $urandom());
      else
        access(1'b0, 1'b1, a, 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
